// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the 16-way round-robin data arbiter.
package arb_pkg;
    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;
endpackage

// File: rtl/mux16_rr_arbiter_mux.sv
// 16:1 word mux over a flattened input bus; slot i lives at d_i[i*N +: N].
module mux_16_1 #(
    parameter int N = 32
) (
    input  logic [16*N-1:0] d_i,
    input  logic [3:0]      s_i,
    output logic [N-1:0]    y_o
);
    assign y_o = d_i[s_i*N +: N];
endmodule

// File: rtl/mux16_rr_arbiter_rr_pick.sv
// Find-first-set search starting at ptr and wrapping modulo 16.
module rr_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [SEL_W-1:0]   idx_o
);
    logic [SEL_W-1:0] cand;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // 4-bit add wraps 15 -> 0 naturally.
            cand = ptr_i + SEL_W'(i);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end
endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter with burst lock sharing one N-bit path into a 1-entry
// valid/ready output register.
module mux16_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_lock,
    input  logic [NUM_REQ*N-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic [SEL_W-1:0]     out_src,
    output logic                 dbg_state_o,
    output logic [SEL_W-1:0]     dbg_ptr_o
);
    // Handshakes: a transfer happens at a rising edge when valid&ready (req&gnt
    // upstream, out_valid&out_ready downstream); the sender holds its word until then.

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    logic             valid_q, valid_d;
    logic [N-1:0]     data_q, data_d;
    logic [SEL_W-1:0] src_q, src_d;

    logic             pick_valid;
    logic [SEL_W-1:0] pick_idx;
    logic [SEL_W-1:0] winner;
    logic             owner_holds;
    logic             slot_free;
    logic             xfer;
    logic [N-1:0]     mux_word;

    rr_pick u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    mux_16_1 #(.N(N)) u_mux (
        .d_i (req_data),
        .s_i (winner),
        .y_o (mux_word)
    );

    assign owner_holds = (state_q == ARB_LOCKED) && req[owner_q];
    assign winner      = owner_holds ? owner_q : pick_idx;
    assign slot_free   = !valid_q || out_ready;
    assign xfer        = slot_free && pick_valid && rst_n;

    always_comb begin
        gnt = '0;
        if (xfer) gnt[winner] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        if (xfer) begin
            data_d  = mux_word;
            src_d   = winner;
            valid_d = 1'b1;
            ptr_d   = winner + 1'b1;
            if (req_lock[winner]) begin
                state_d = ARB_LOCKED;
                owner_d = winner;
            end else begin
                state_d = ARB_FREE;
            end
        end else begin
            // Lock is dropped as soon as the owner stops requesting, transfer or not.
            if (state_q == ARB_LOCKED && !req[owner_q]) state_d = ARB_FREE;
            if (valid_q && out_ready) valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_FREE;
            ptr_q   <= '0;
            owner_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_src     = src_q;
    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed-vector bench for mux16_rr_arbiter with hand-computed expectations.
module tb_mux16_rr_arbiter;
    localparam int N = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [15:0]     req = '0;
    logic [15:0]     req_lock = '0;
    logic [16*N-1:0] req_data = '0;
    logic [15:0]     gnt;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [N-1:0]    out_data;
    logic [3:0]      out_src;
    logic            dbg_state;
    logic [3:0]      dbg_ptr;

    int vec_cnt = 0;
    int err_cnt = 0;

    mux16_rr_arbiter #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_lock    (req_lock),
        .req_data    (req_data),
        .gnt         (gnt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_src     (out_src),
        .dbg_state_o (dbg_state),
        .dbg_ptr_o   (dbg_ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        #1;
    endtask

    function automatic logic [31:0] word_of(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    initial begin
        @(posedge clk);
        #1;
        // Reset state
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  out_data, 32'd0);
        check("rst_src",   32'(out_src), 32'd0);
        check("rst_ptr",   32'(dbg_ptr), 32'd0);
        check("rst_gnt",   32'(gnt), 32'd0);
        rst_n = 1'b1;

        // Single requester
        req = 16'h0001;
        req_data[0 +: N] = 32'hA5A5_0000;
        out_ready = 1'b1;
        #1 check("t1_gnt", 32'(gnt), 32'h0001);
        step();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data",  out_data, 32'hA5A5_0000);
        check("t1_src",   32'(out_src), 32'd0);
        check("t1_ptr",   32'(dbg_ptr), 32'd1);
        req = '0;
        step();
        check("t1_drain", 32'(out_valid), 32'd0);

        // All requesting: strict rotation 0..15 then wrap to 0
        do_reset();
        for (int i = 0; i < 16; i++) req_data[i*N +: N] = word_of(i);
        req = 16'hFFFF;
        for (int k = 0; k < 17; k++) begin
            #1 check("t2_gnt", 32'(gnt), 32'h1 << (k % 16));
            step();
            check("t2_src",  32'(out_src), 32'(k % 16));
            check("t2_data", out_data, word_of(k % 16));
        end
        check("t2_ptr", 32'(dbg_ptr), 32'd1);

        // Wrap-around priority: 15 beats 0 when ptr=1
        req = 16'h8001;
        #1 check("t3_gnt15", 32'(gnt), 32'h8000);
        step();
        check("t3_src15", 32'(out_src), 32'd15);
        check("t3_ptr0",  32'(dbg_ptr), 32'd0);
        #1 check("t3_gnt0", 32'(gnt), 32'h0001);
        step();
        check("t3_src0", 32'(out_src), 32'd0);
        check("t3_ptr1", 32'(dbg_ptr), 32'd1);

        // Backpressure: full slot, consumer stalled
        out_ready = 1'b0;
        req = 16'h0004;
        for (int k = 0; k < 5; k++) begin
            #1 check("t4_gnt_stall", 32'(gnt), 32'd0);
            step();
            check("t4_src_hold",  32'(out_src), 32'd0);
            check("t4_data_hold", out_data, word_of(0));
            check("t4_valid",     32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1 check("t4_gnt_refill", 32'(gnt), 32'h0004);
        step();
        check("t4_src2",  32'(out_src), 32'd2);
        check("t4_data2", out_data, word_of(2));
        check("t4_valid2", 32'(out_valid), 32'd1);

        // Burst lock on 3, then release
        req = 16'h0009;
        req_lock = 16'h0008;
        for (int k = 0; k < 3; k++) begin
            #1 check("t5_gnt3", 32'(gnt), 32'h0008);
            step();
            check("t5_src3",   32'(out_src), 32'd3);
            check("t5_locked", 32'(dbg_state), 32'd1);
        end
        req = 16'h0001;
        req_lock = '0;
        #1 check("t5_gnt0", 32'(gnt), 32'h0001);
        step();
        check("t5_src0",  32'(out_src), 32'd0);
        check("t5_free",  32'(dbg_state), 32'd0);

        // Async reset mid-burst
        req = 16'h0009;
        req_lock = 16'h0008;
        step();
        check("t6_src3",   32'(out_src), 32'd3);
        check("t6_locked", 32'(dbg_state), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid_rst", 32'(out_valid), 32'd0);
        check("t6_data_rst",  out_data, 32'd0);
        check("t6_gnt_rst",   32'(gnt), 32'd0);
        check("t6_state_rst", 32'(dbg_state), 32'd0);
        check("t6_ptr_rst",   32'(dbg_ptr), 32'd0);
        #1 rst_n = 1'b1;
        req_lock = '0;
        #1 check("t6_gnt_after", 32'(gnt), 32'h0001);
        step();
        check("t6_src_after", 32'(out_src), 32'd0);
        check("t6_data_after", out_data, word_of(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
